// File: rtl/debounced_input_sync.sv
// Multi-channel input synchroniser and debouncer with edge pulses and optional
// hold-to-auto-repeat pulse train, for switches/buttons feeding the game FSM.
module debounced_input_sync #(
    parameter int WIDTH           = 3,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 10,
    parameter int REPEAT_RATE     = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sig,
    output logic [WIDTH-1:0] sigSync,
    output logic [WIDTH-1:0] rising_ind,
    output logic [WIDTH-1:0] falling_ind,
    output logic [WIDTH-1:0] repeat_ind,
    output logic [WIDTH-1:0] press_ind
);

    localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TIMER_W = $clog2(REP_MAX + 1);

    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DELAY_LAST = TIMER_W'(REPEAT_DELAY - 1);
    localparam logic [TIMER_W-1:0] RATE_LAST  = TIMER_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_REPEAT
    } rep_state_t;

    for (genvar ch = 0; ch < WIDTH; ch++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [CNT_W-1:0]       cnt_q;
        logic                   level_q;
        logic                   rise_q;
        logic                   fall_q;
        logic                   raw_s;
        logic                   accept;

        assign raw_s  = sync_q[SYNC_STAGES-1];
        // A new level is taken on the DEBOUNCE_CYCLES-th consecutive mismatch.
        assign accept = (raw_s != level_q) && (cnt_q == CNT_LAST);

        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sync_q  <= '0;
                cnt_q   <= '0;
                level_q <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], sig[ch]};
                rise_q <= accept & raw_s;
                fall_q <= accept & ~raw_s;
                if (raw_s == level_q) begin
                    cnt_q <= '0;
                end else if (accept) begin
                    level_q <= raw_s;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end

        assign sigSync[ch]     = level_q;
        assign rising_ind[ch]  = rise_q;
        assign falling_ind[ch] = fall_q;

        if (REPEAT_EN != 0) begin : g_rep
            rep_state_t         state_q;
            logic [TIMER_W-1:0] timer_q;
            logic               rep_q;

            // An accepted fall wins over a repeat pulse due in the same cycle.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    state_q <= ST_IDLE;
                    timer_q <= '0;
                    rep_q   <= 1'b0;
                end else begin
                    rep_q <= 1'b0;
                    case (state_q)
                        ST_IDLE: begin
                            if (accept && raw_s) begin
                                state_q <= ST_HOLD;
                                timer_q <= '0;
                            end
                        end
                        ST_HOLD, ST_REPEAT: begin
                            if (accept && !raw_s) begin
                                state_q <= ST_IDLE;
                                timer_q <= '0;
                            end else if (timer_q == ((state_q == ST_HOLD) ? DELAY_LAST : RATE_LAST)) begin
                                rep_q   <= 1'b1;
                                state_q <= ST_REPEAT;
                                timer_q <= '0;
                            end else begin
                                timer_q <= timer_q + 1'b1;
                            end
                        end
                        default: begin
                            state_q <= ST_IDLE;
                            timer_q <= '0;
                        end
                    endcase
                end
            end

            assign repeat_ind[ch] = rep_q;
        end else begin : g_no_rep
            assign repeat_ind[ch] = 1'b0;
        end
    end

    assign press_ind = rising_ind | repeat_ind;

endmodule

// File: doc/debounced_input_sync.md
Name: debounced_input_sync

Overview:
Parametrised successor to the 3-bit digit-input synchroniser. Synchronises WIDTH asynchronous switch/button inputs through a configurable flop chain and debounces each channel with a per-channel stability counter. Emits one-cycle rising, falling and press pulses, plus an optional hold-to-auto-repeat pulse train for incrementing guess digits. Sits between board I/O and the game FSM.

Parameters:
WIDTH, 3, number of independent input channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
DEBOUNCE_CYCLES, 4, consecutive cycles a changed level must persist before acceptance (>=1)
REPEAT_EN, 1, 1 = auto-repeat enabled; 0 = repeat_ind tied low, repeat FSM removed
REPEAT_DELAY, 10, cycles from rising_ind to first repeat pulse (>=1)
REPEAT_RATE, 5, cycles between subsequent repeat pulses (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
sig  in  WIDTH  raw asynchronous inputs
sigSync  out  WIDTH  synchronised, debounced level
rising_ind  out  WIDTH  1-cycle pulse on accepted 0->1 of sigSync
falling_ind  out  WIDTH  1-cycle pulse on accepted 1->0 of sigSync
repeat_ind  out  WIDTH  1-cycle auto-repeat pulse while held
press_ind  out  WIDTH  rising_ind | repeat_ind

Behaviour:
- Reset: clk is clk and reset is reset, asynchronous, active-low. While reset=0, all sync flops, debounce counters, sigSync, rising_ind, falling_ind, repeat_ind, press_ind, repeat timers and FSMs = 0/IDLE.
- Sync: per channel, a SYNC_STAGES-deep shift register; raw_s = last stage.
- Debounce, per channel: counter cnt, width clog2(DEBOUNCE_CYCLES+1).
  - raw_s == sigSync: cnt <= 0.
  - raw_s != sigSync and cnt == DEBOUNCE_CYCLES-1: sigSync <= raw_s, cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - A mismatch shorter than DEBOUNCE_CYCLES is discarded with no output change.
- Latency: a clean input step changes sigSync exactly SYNC_STAGES+DEBOUNCE_CYCLES clock edges after it is first captured.
- Edge pulses: registered, asserted in the same cycle sigSync takes its new value, for exactly 1 cycle. rising_ind and falling_ind are never both high on one channel.
- Repeat FSM, per channel, REPEAT_EN=1:
  - IDLE: on accepted rise -> HOLD, timer <= 0.
  - HOLD: timer increments each cycle. When timer == REPEAT_DELAY-1, pulse repeat_ind -> REPEAT, timer <= 0.
  - REPEAT: timer increments. When timer == REPEAT_RATE-1, pulse repeat_ind, timer <= 0.
  - HOLD/REPEAT: accepted fall -> IDLE, timer <= 0. The fall takes priority over a coincident repeat pulse (no pulse that cycle).
  - Net timing: first repeat_ind REPEAT_DELAY cycles after rising_ind, then every REPEAT_RATE cycles while held.
- Channels are fully independent; simultaneous events on different channels are all reported in the same cycle.
- Reset mid-operation: all state is cleared immediately and no pulse is emitted during reset. After release, an input held high is re-accepted as a fresh rise after full latency.
- Timer width: clog2(max(REPEAT_DELAY, REPEAT_RATE)+1). Timers saturate-free; they are cleared on every wrap.

Test Plan:
(WIDTH=3, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=5)
1. Reset: hold reset=0 with sig=3'b111 -> all outputs 0. Release reset -> sigSync=3'b111 and rising_ind=3'b111 for 1 cycle, 6 edges after the first capture.
2. Clean step: sig[0] 0->1 held -> sigSync[0] rises 6 edges after capture. rising_ind[0] and press_ind[0] high 1 cycle; other channels quiet.
3. Glitch reject: sig[1] high for 3 cycles then low -> sigSync[1], rising_ind[1] and falling_ind[1] stay 0. Same with a 4-cycle pulse -> rise accepted, then fall accepted.
4. Auto-repeat: hold sig[2] high for 40 cycles after acceptance -> repeat_ind[2] at +10, +15, +20, +25, +30, +35 after rising_ind. press_ind[2] equals the OR of both. On release, falling_ind[2] pulses once and repeat stops.
5. Priority: release sig[2] so the accepted fall lands on a scheduled repeat cycle -> falling_ind=1, repeat_ind=0; FSM returns to IDLE.
6. Async reset mid-hold: assert reset during REPEAT -> outputs clear asynchronously. With REPEAT_EN=0, repeat_ind is constantly 0 and press_ind equals rising_ind.
